// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave word memory with programmable wait states, byte-masked writes,
// an address window and a synchronous preload port for loading programs.
module avalon_wait_ram #(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);
    localparam logic [15:0] CNT_RELOAD = 16'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q;
    logic [15:0]    cnt_q;
    logic [31:0]    readdata_q;
    logic [31:0]    mem [DEPTH];

    logic [31:0]    offset;
    logic           inRange;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  preIdx;
    logic           unusedPreloadLsbs;

    // Unsigned subtraction makes addresses below the window wrap to huge offsets.
    assign offset            = address - BASE_ADDR;
    assign inRange           = offset < SPAN;
    assign idx               = offset[AW+1:2];
    assign preIdx            = AW'(inst_addr[7:2]);
    assign unusedPreloadLsbs = ^inst_addr[1:0];

    assign readdata = readdata_q;

    always_comb begin
        waitrequest = 1'b0;
        unique case (state_q)
            IDLE:    waitrequest = read | write;
            BUSY:    waitrequest = 1'b1;
            DONE:    waitrequest = 1'b0;
            default: waitrequest = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            readdata_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if ((read | write) && !inst_input) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_RELOAD;
                    end
                end
                BUSY: begin
                    if (!read && !write) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 16'd0) begin
                        state_q    <= DONE;
                        readdata_q <= inRange ? mem[idx] : 32'd0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory has no reset; the preload assignment comes last so it wins a same-word clash.
    always_ff @(posedge clk) begin
        if (state_q == DONE && write && inRange) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
        if (inst_input) begin
            mem[preIdx] <= instruction;
        end
    end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed bench for avalon_wait_ram: handshake latency, masked stores, window
// decode, abort, mid-transaction reset and preload contention.
module tb_avalon_wait_ram;

    localparam int          WAIT_CYCLES = 1;
    localparam int          EXP_WAITS   = WAIT_CYCLES + 1;
    localparam logic [31:0] BASE        = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = 32'd0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        waitrequest;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] readdata;
    logic        inst_input = 1'b0;
    logic [7:0]  inst_addr = 8'd0;
    logic [31:0] instruction = 32'd0;

    int          checkCount = 0;
    int          errorCount = 0;
    int          cycles;
    logic [31:0] rd;

    avalon_wait_ram #(
        .DEPTH(256),
        .BASE_ADDR(BASE),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .write(write),
        .read(read),
        .waitrequest(waitrequest),
        .writedata(writedata),
        .byteenable(byteenable),
        .readdata(readdata),
        .inst_input(inst_input),
        .inst_addr(inst_addr),
        .instruction(instruction)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Called right after driving a request on a falling edge; counts cycles with waitrequest high.
    task automatic waitForReady(output int nWait, output logic [31:0] data);
        nWait = 0;
        #1;
        while (waitrequest === 1'b1 && nWait < 50) begin
            nWait++;
            @(negedge clk);
            #1;
        end
        if (waitrequest !== 1'b0) begin
            checkOutput("handshakeTimeout", {31'd0, waitrequest}, 32'd0);
        end
        data = readdata;
    endtask

    task automatic applyStimulus(input logic doWrite, input logic doRead, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] be,
                                 output int nWait, output logic [31:0] rdata);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        byteenable = be;
        write      = doWrite;
        read       = doRead;
        waitForReady(nWait, rdata);
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic preloadWord(input logic [7:0] offs, input logic [31:0] word);
        @(negedge clk);
        inst_input  = 1'b1;
        inst_addr   = offs;
        instruction = word;
        @(negedge clk);
        inst_input  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("resetReaddata", readdata, 32'd0);
        checkOutput("resetWait", {31'd0, waitrequest}, 32'd0);

        preloadWord(8'h04, 32'h2404FFFF);
        applyStimulus(1'b0, 1'b1, BASE + 32'h4, 32'd0, 4'h0, cycles, rd);
        checkOutput("fetchWaits", 32'(cycles), 32'(EXP_WAITS));
        checkOutput("fetchData", rd, 32'h2404FFFF);

        preloadWord(8'h0C, 32'h11223344);
        applyStimulus(1'b1, 1'b0, BASE + 32'hC, 32'hAABBCCDD, 4'b0101, cycles, rd);
        checkOutput("maskWriteWaits", 32'(cycles), 32'(EXP_WAITS));
        applyStimulus(1'b0, 1'b1, BASE + 32'hC, 32'd0, 4'h0, cycles, rd);
        checkOutput("maskReadBack", rd, 32'h11BB33DD);

        preloadWord(8'h00, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 32'h00000000, 32'hDEADBEEF, 4'hF, cycles, rd);
        checkOutput("oorWriteWaits", 32'(cycles), 32'(EXP_WAITS));
        applyStimulus(1'b0, 1'b1, 32'h00000000, 32'd0, 4'h0, cycles, rd);
        checkOutput("oorReadWaits", 32'(cycles), 32'(EXP_WAITS));
        checkOutput("oorReadData", rd, 32'h0);
        applyStimulus(1'b0, 1'b1, BASE, 32'd0, 4'h0, cycles, rd);
        checkOutput("word0Intact", rd, 32'hCAFEF00D);

        applyStimulus(1'b1, 1'b0, BASE + 32'h3FC, 32'h12345678, 4'hF, cycles, rd);
        applyStimulus(1'b0, 1'b1, BASE + 32'h3FC, 32'd0, 4'h0, cycles, rd);
        checkOutput("lastWord", rd, 32'h12345678);
        applyStimulus(1'b0, 1'b1, BASE + 32'h400, 32'd0, 4'h0, cycles, rd);
        checkOutput("pastTop", rd, 32'h0);
        applyStimulus(1'b0, 1'b1, BASE - 32'h4, 32'd0, 4'h0, cycles, rd);
        checkOutput("belowBase", rd, 32'h0);

        applyStimulus(1'b1, 1'b0, BASE + 32'hC, 32'h55555555, 4'h0, cycles, rd);
        checkOutput("be0Waits", 32'(cycles), 32'(EXP_WAITS));
        applyStimulus(1'b0, 1'b1, BASE + 32'hC, 32'd0, 4'h0, cycles, rd);
        checkOutput("be0Unchanged", rd, 32'h11BB33DD);

        @(negedge clk);
        address = BASE + 32'h4;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        #1;
        checkOutput("abortBusyWait", {31'd0, waitrequest}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("abortIdleWait", {31'd0, waitrequest}, 32'd0);
        checkOutput("abortReaddata", readdata, 32'h11BB33DD);
        applyStimulus(1'b0, 1'b1, BASE + 32'h4, 32'd0, 4'h0, cycles, rd);
        checkOutput("postAbortWaits", 32'(cycles), 32'(EXP_WAITS));
        checkOutput("postAbortData", rd, 32'h2404FFFF);

        @(negedge clk);
        address    = BASE + 32'hC;
        writedata  = 32'h00000000;
        byteenable = 4'hF;
        write      = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        write = 1'b0;
        #2;
        checkOutput("midResetReaddata", readdata, 32'd0);
        checkOutput("midResetWait", {31'd0, waitrequest}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, BASE + 32'hC, 32'd0, 4'h0, cycles, rd);
        checkOutput("midResetWordKept", rd, 32'h11BB33DD);

        @(negedge clk);
        address     = BASE + 32'h10;
        read        = 1'b1;
        inst_input  = 1'b1;
        inst_addr   = 8'h10;
        instruction = 32'h8C820000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("preloadStall", {31'd0, waitrequest}, 32'd1);
            @(negedge clk);
        end
        inst_input = 1'b0;
        waitForReady(cycles, rd);
        checkOutput("contentionWaits", 32'(cycles), 32'(EXP_WAITS));
        checkOutput("contentionData", rd, 32'h8C820000);
        @(posedge clk);
        #1;
        read = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
